// File: rtl/tlk_pkg.sv
// ============================================================================
// Module : tlk_pkg
// Shared constants, state encodings and word classifier for the TLK RX monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tlk_pkg;

    localparam logic [15:0] K28_5_IDLE   = 16'hC5BC;

    localparam logic [1:0]  ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0]  ST_UP        = 2'd1;
    localparam logic [1:0]  ST_RELINK    = 2'd2;

    typedef enum logic [1:0] {
        WC_IDLE    = 2'd0,
        WC_DATA    = 2'd1,
        WC_ERR     = 2'd2,
        WC_NEUTRAL = 2'd3
    } word_class_e;

    // An error flag dominates regardless of DV; a non-idle control word is neutral.
    function automatic word_class_e classify(input logic dv, input logic er,
                                             input logic [15:0] rxd);
        if (er)
            return WC_ERR;
        else if (dv)
            return WC_DATA;
        else if (rxd == K28_5_IDLE)
            return WC_IDLE;
        else
            return WC_NEUTRAL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tlk_rx_link_mon_if.sv
// ============================================================================
// Module : tlk_rx_link_mon_if
// TLK receive pins, monitor controls and link status bundle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface tlk_rx_link_mon_if;
    logic        ena;
    logic        RX_DV;
    logic        RX_ER;
    logic [15:0] RXD;
    logic        clr_cnt;
    logic        link_up;
    logic        live;
    logic        sync_lost;
    logic [15:0] err_cnt;

    modport master (
        output ena, RX_DV, RX_ER, RXD, clr_cnt,
        input  link_up, live, sync_lost, err_cnt
    );

    modport slave (
        input  ena, RX_DV, RX_ER, RXD, clr_cnt,
        output link_up, live, sync_lost, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/tlk_run_cnt.sv
// ============================================================================
// Module : tlk_run_cnt
// Saturating consecutive-event counter; hit flags the increment reaching TC.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tlk_run_cnt
    import tlk_pkg::*;
#(
    parameter int TC = 64
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic inc,
    input  wire logic clr,
    output logic      hit
);

    localparam logic [15:0] c_tc_m1 = 16'(TC - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (inc && (r_cnt != 16'hFFFF))
            r_cnt <= r_cnt + 16'd1;
    end

    // Flags the edge on which the run becomes TC, so the caller can act on it.
    assign hit = inc && !clr && (r_cnt == c_tc_m1);

endmodule

`default_nettype wire

// File: rtl/tlk_rx_link_mon.sv
// ============================================================================
// Module : tlk_rx_link_mon
// TLK2501 receive link monitor: lock/loss FSM, relink handshake, error count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tlk_rx_link_mon
    import tlk_pkg::*;
#(
    parameter int LOCK_CNT   = 64,
    parameter int LOSS_CNT   = 4,
    parameter int LIVE_PULSE = 8,
    parameter int TIMEOUT    = 65000
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    tlk_rx_link_mon_if.slave   bus
);

    localparam logic [15:0] c_tmo_last  = 16'(TIMEOUT - 1);
    localparam logic [15:0] c_live_last = 16'(LIVE_PULSE - 1);

    logic        r_rx_dv;
    logic        r_rx_er;
    logic [15:0] r_rxd;
    logic [1:0]  r_state;
    logic [15:0] r_tmo;
    logic [15:0] r_live_cnt;
    logic        r_link_up;
    logic        r_live;
    logic        r_sync_lost;
    logic [15:0] r_err_cnt;

    word_class_e w_class;
    logic        w_idle_inc;
    logic        w_err_inc;
    logic        w_lock;
    logic        w_loss;
    logic [1:0]  w_state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_dv <= 1'b0;
            r_rx_er <= 1'b0;
            r_rxd   <= '0;
        end else begin
            r_rx_dv <= bus.RX_DV;
            r_rx_er <= bus.RX_ER;
            r_rxd   <= bus.RXD;
        end
    end

    assign w_class    = classify(r_rx_dv, r_rx_er, r_rxd);
    assign w_idle_inc = bus.ena && (r_state == ST_WAIT_LOCK) && (w_class == WC_IDLE);
    assign w_err_inc  = bus.ena && (r_state == ST_UP) && (w_class == WC_ERR);

    tlk_run_cnt #(.TC(LOCK_CNT)) u_idle_run (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_idle_inc),
        .clr   (!w_idle_inc),
        .hit   (w_lock)
    );

    tlk_run_cnt #(.TC(LOSS_CNT)) u_err_run (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_err_inc),
        .clr   (!w_err_inc),
        .hit   (w_loss)
    );

    // Lock wins over a timeout landing on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        if (!bus.ena) begin
            w_state_nxt = ST_WAIT_LOCK;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (w_lock)
                        w_state_nxt = ST_UP;
                    else if (r_tmo == c_tmo_last)
                        w_state_nxt = ST_RELINK;
                end
                ST_UP: begin
                    if (w_loss)
                        w_state_nxt = ST_RELINK;
                end
                ST_RELINK: begin
                    if (r_live_cnt == c_live_last)
                        w_state_nxt = ST_WAIT_LOCK;
                end
                default: w_state_nxt = ST_WAIT_LOCK;
            endcase
        end
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_WAIT_LOCK;
            r_tmo       <= '0;
            r_live_cnt  <= '0;
            r_link_up   <= 1'b0;
            r_live      <= 1'b0;
            r_sync_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmo       <= ((r_state == ST_WAIT_LOCK) && (w_state_nxt == ST_WAIT_LOCK) && bus.ena)
                           ? r_tmo + 16'd1 : '0;
            r_live_cnt  <= ((r_state == ST_RELINK) && (w_state_nxt == ST_RELINK))
                           ? r_live_cnt + 16'd1 : '0;
            r_link_up   <= (w_state_nxt == ST_UP);
            r_live      <= (w_state_nxt == ST_RELINK);
            r_sync_lost <= (r_state == ST_UP) && (w_state_nxt == ST_RELINK);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err_cnt <= '0;
        else if (bus.clr_cnt)
            r_err_cnt <= '0;
        else if (w_err_inc && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign bus.link_up   = r_link_up;
    assign bus.live      = r_live;
    assign bus.sync_lost = r_sync_lost;
    assign bus.err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tlk_rx_link_mon.sv
// ============================================================================
// Module : tb_tlk_rx_link_mon
// Directed bench for tlk_rx_link_mon: vector table plus lock/timeout/saturation sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tlk_rx_link_mon;
    import tlk_pkg::*;

    localparam int W_IDLE = 0;
    localparam int W_DATA = 1;
    localparam int W_ERR  = 2;

    typedef struct {
        int          n;
        int          w;
        logic        ena;
        logic        clr;
        logic        lu;
        logic        lv;
        logic        sl;
        logic [15:0] ec;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n0 = 1'b0;
    logic rst_n1 = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    tlk_rx_link_mon_if bus0 ();
    tlk_rx_link_mon_if bus1 ();

    tlk_rx_link_mon u_dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (bus0)
    );

    tlk_rx_link_mon #(
        .LOCK_CNT   (64),
        .LOSS_CNT   (65535),
        .LIVE_PULSE (8),
        .TIMEOUT    (100)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (bus1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set0(input int w, input logic ena, input logic clr);
        bus0.ena     = ena;
        bus0.clr_cnt = clr;
        bus0.RX_DV   = (w == W_DATA);
        bus0.RX_ER   = (w == W_ERR);
        bus0.RXD     = (w == W_IDLE) ? K28_5_IDLE : ((w == W_DATA) ? 16'h1234 : 16'h0000);
    endtask

    task automatic set1(input int w);
        bus1.ena     = 1'b1;
        bus1.clr_cnt = 1'b0;
        bus1.RX_DV   = (w == W_DATA);
        bus1.RX_ER   = (w == W_ERR);
        bus1.RXD     = (w == W_IDLE) ? K28_5_IDLE : ((w == W_DATA) ? 16'h1234 : 16'h0000);
    endtask

    function automatic vec_t mk(input int n, input int w, input logic ena, input logic clr,
                                input logic lu, input logic lv, input logic sl,
                                input logic [15:0] ec);
        vec_t v;
        v.n = n; v.w = w; v.ena = ena; v.clr = clr;
        v.lu = lu; v.lv = lv; v.sl = sl; v.ec = ec;
        return v;
    endfunction

    task automatic reset0();
        set0(W_DATA, 1'b1, 1'b0);
        rst_n0 = 1'b0;
        step();
        step();
        rst_n0 = 1'b1;
    endtask

    initial begin
        logic live_seen;

        // Rows continue from a locked link with IDLE at the pins; expectations include the input-register lag.
        vt.push_back(mk( 3, W_ERR,  1, 0, 1, 0, 0, 16'd2));
        vt.push_back(mk( 1, W_DATA, 1, 0, 1, 0, 0, 16'd3));
        vt.push_back(mk( 3, W_ERR,  1, 0, 1, 0, 0, 16'd5));
        vt.push_back(mk( 2, W_IDLE, 1, 0, 1, 0, 0, 16'd6));
        vt.push_back(mk( 4, W_ERR,  1, 0, 1, 0, 0, 16'd9));
        vt.push_back(mk( 1, W_ERR,  1, 0, 0, 1, 1, 16'd10));
        vt.push_back(mk( 1, W_IDLE, 1, 0, 0, 1, 0, 16'd10));
        vt.push_back(mk( 6, W_IDLE, 1, 0, 0, 1, 0, 16'd10));
        vt.push_back(mk( 1, W_IDLE, 1, 0, 0, 0, 0, 16'd10));
        vt.push_back(mk(63, W_IDLE, 1, 0, 0, 0, 0, 16'd10));
        vt.push_back(mk( 1, W_IDLE, 1, 0, 1, 0, 0, 16'd10));
        vt.push_back(mk( 1, W_IDLE, 1, 1, 1, 0, 0, 16'd0));
        vt.push_back(mk( 3, W_ERR,  1, 0, 1, 0, 0, 16'd2));
        vt.push_back(mk( 1, W_DATA, 1, 0, 1, 0, 0, 16'd3));
        vt.push_back(mk( 2, W_ERR,  1, 0, 1, 0, 0, 16'd4));
        vt.push_back(mk( 1, W_ERR,  1, 0, 1, 0, 0, 16'd5));
        vt.push_back(mk( 1, W_DATA, 1, 1, 1, 0, 0, 16'd0));
        vt.push_back(mk( 1, W_DATA, 1, 0, 1, 0, 0, 16'd0));
        vt.push_back(mk( 4, W_ERR,  1, 0, 1, 0, 0, 16'd3));
        vt.push_back(mk( 1, W_ERR,  1, 0, 0, 1, 1, 16'd4));
        vt.push_back(mk( 1, W_IDLE, 1, 0, 0, 1, 0, 16'd4));
        vt.push_back(mk( 1, W_IDLE, 1, 0, 0, 1, 0, 16'd4));
        vt.push_back(mk( 1, W_IDLE, 0, 0, 0, 0, 0, 16'd4));
        vt.push_back(mk(63, W_IDLE, 1, 0, 0, 0, 0, 16'd4));
        vt.push_back(mk( 1, W_IDLE, 1, 0, 1, 0, 0, 16'd4));
        vt.push_back(mk( 2, W_ERR,  0, 0, 0, 0, 0, 16'd4));

        set1(W_DATA);
        reset0();
        chk("reset_link_up",   bus0.link_up,   1'b0);
        chk("reset_live",      bus0.live,      1'b0);
        chk("reset_sync_lost", bus0.sync_lost, 1'b0);
        chk("reset_err_cnt",   bus0.err_cnt,   16'd0);

        // 64 IDLE words: link_up on edge 65 counted from the first IDLE at the pins.
        set0(W_IDLE, 1'b1, 1'b0);
        live_seen = 1'b0;
        for (int k = 1; k <= 65; k++) begin
            step();
            live_seen |= bus0.live;
            if (k == 64) chk("lock_edge64", bus0.link_up, 1'b0);
            if (k == 65) chk("lock_edge65", bus0.link_up, 1'b1);
        end
        chk("lock_no_live", live_seen, 1'b0);

        // 63 IDLE, 1 DATA, 64 IDLE: only the second run locks.
        reset0();
        for (int k = 1; k <= 129; k++) begin
            set0((k == 64) ? W_DATA : W_IDLE, 1'b1, 1'b0);
            step();
            if (k == 65)  chk("broken_run_edge65",  bus0.link_up, 1'b0);
            if (k == 128) chk("broken_run_edge128", bus0.link_up, 1'b0);
            if (k == 129) chk("broken_run_edge129", bus0.link_up, 1'b1);
        end

        for (int i = 0; i < vt.size(); i++) begin
            for (int c = 0; c < vt[i].n; c++) begin
                set0(vt[i].w, vt[i].ena, vt[i].clr);
                step();
            end
            chk($sformatf("row%0d_link_up", i),   bus0.link_up,   vt[i].lu);
            chk($sformatf("row%0d_live", i),      bus0.live,      vt[i].lv);
            chk($sformatf("row%0d_sync_lost", i), bus0.sync_lost, vt[i].sl);
            chk($sformatf("row%0d_err_cnt", i),   bus0.err_cnt,   vt[i].ec);
        end

        // Timeout instance (TIMEOUT=100): pulses every 108 cycles with no IDLE.
        set1(W_DATA);
        rst_n1 = 1'b0;
        step();
        rst_n1 = 1'b1;
        for (int k = 1; k <= 211; k++) begin
            step();
            if (k == 99)  chk("tmo_edge99",  bus1.live, 1'b0);
            if (k == 100) chk("tmo_edge100", bus1.live, 1'b1);
            if (k == 107) chk("tmo_edge107", bus1.live, 1'b1);
            if (k == 108) chk("tmo_edge108", bus1.live, 1'b0);
            if (k == 207) chk("tmo_edge207", bus1.live, 1'b0);
            if (k == 208) chk("tmo_edge208", bus1.live, 1'b1);
        end
        // Reset in the middle of the relink pulse clears live without a clock.
        #2;
        rst_n1 = 1'b0;
        #1;
        chk("async_reset_live", bus1.live, 1'b0);
        step();
        rst_n1 = 1'b1;
        live_seen = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k < 100) live_seen |= bus1.live;
            if (k == 100) chk("post_reset_tmo_edge100", bus1.live, 1'b1);
        end
        chk("post_reset_no_resume", live_seen, 1'b0);

        // Saturation: 65540 ERR words, broken once by DATA so the loss run never completes.
        rst_n1 = 1'b0;
        step();
        rst_n1 = 1'b1;
        set1(W_IDLE);
        for (int k = 1; k <= 65; k++) step();
        chk("sat_locked", bus1.link_up, 1'b1);
        set1(W_ERR);
        for (int k = 0; k < 60000; k++) step();
        set1(W_DATA);
        step();
        chk("sat_mid_err_cnt", bus1.err_cnt, 16'd60000);
        set1(W_ERR);
        for (int k = 0; k < 5540; k++) step();
        set1(W_DATA);
        step();
        step();
        chk("sat_err_cnt", bus1.err_cnt, 16'hFFFF);
        chk("sat_link_up", bus1.link_up, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
